// File: rtl/scoreboard_warp.sv
// -----------------------------------------------------------------------------
// scoreboard_warp
//   Per-warp 4-entry scoreboard for in-flight instructions. It sits beside
//   the warp's instruction buffer and does three jobs:
//     - answers hazard and capacity queries (full, empty, dependent),
//     - hands out a 2-bit entry ID on every normal issue grant,
//     - releases entries on ALU/MEM writeback and, for LW/SW, once the
//       buffer reports the replay as finished.
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   src1/src2/dst_IB_Scb [4:0]       register IDs at the buffer read pointer
//   src1/src2/dst_valid_IB_Scb       operand-used flags
//   RP_grt_IB_Scb                    issue grant: allocate the lowest free entry
//   replayable_IB_Scb                granted instruction is LW/SW
//   replay_complete_IB_Scb           replay finished for replay_complete_ScbID_IB_Scb
//   replay_SW_LWbar_IB_Scb           1 = SW, 0 = LW (must match the stored kind)
//   clr_valid/ScbID_ALU_Scb          ALU writeback done for an entry
//   clr_valid/ScbID_MEM_Scb          MEM writeback or per-pass done for an entry
//   full_Scb_IB, empty_Scb_IB        capacity status from registered state
//   dependent_Scb_IB                 RAW/WAW hazard against a valid entry
//   ScbID_Scb_IB [1:0]               lowest free entry (meaningful when not full)
//   err_Scb                          sticky: grant while full, or clear of an invalid entry
// -----------------------------------------------------------------------------
module scoreboard_warp #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] src1_IB_Scb,
  input  logic [4:0] src2_IB_Scb,
  input  logic [4:0] dst_IB_Scb,
  input  logic       src1_valid_IB_Scb,
  input  logic       src2_valid_IB_Scb,
  input  logic       dst_valid_IB_Scb,
  input  logic       RP_grt_IB_Scb,
  input  logic       replayable_IB_Scb,
  input  logic       replay_complete_IB_Scb,
  input  logic [1:0] replay_complete_ScbID_IB_Scb,
  input  logic       replay_SW_LWbar_IB_Scb,
  input  logic       clr_valid_ALU_Scb,
  input  logic [1:0] clr_ScbID_ALU_Scb,
  input  logic       clr_valid_MEM_Scb,
  input  logic [1:0] clr_ScbID_MEM_Scb,
  output logic       full_Scb_IB,
  output logic       empty_Scb_IB,
  output logic       dependent_Scb_IB,
  output logic [1:0] ScbID_Scb_IB,
  output logic       err_Scb
);

  localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
  localparam logic [NUM_ENTRIES-1:0] NONE     = {NUM_ENTRIES{1'b0}};

  // Entry state
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_dst_valid;
  logic [NUM_ENTRIES-1:0] r_pending;
  logic [NUM_ENTRIES-1:0] r_incomplete;
  logic [NUM_ENTRIES-1:0] r_is_sw;
  logic [4:0]             r_dst [NUM_ENTRIES];
  logic                   r_err;

  logic                   w_full;
  logic                   w_empty;
  logic [1:0]             w_free_id;
  logic                   w_alloc;
  logic [NUM_ENTRIES-1:0] w_alloc_oh;
  logic [NUM_ENTRIES-1:0] w_alu_oh;
  logic [NUM_ENTRIES-1:0] w_mem_oh;
  logic [NUM_ENTRIES-1:0] w_clr_oh;
  logic                   w_clr_bad;
  logic [NUM_ENTRIES-1:0] w_rc_oh;
  logic [NUM_ENTRIES-1:0] w_rc_ok;
  logic [NUM_ENTRIES-1:0] w_pending_nx;
  logic [NUM_ENTRIES-1:0] w_incomplete_nx;
  logic [NUM_ENTRIES-1:0] w_valid_nx;
  logic                   w_err_nx;
  logic                   w_dep;

  assign w_full  = &r_valid;
  assign w_empty = ~|r_valid;
  assign w_alloc = RP_grt_IB_Scb & ~w_full;

  // Lowest-index free entry; scanning from the top lets the lowest win.
  always_comb begin
    w_free_id = 2'b00;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_id = i[1:0];
      end else begin
        w_free_id = w_free_id;
      end
    end
  end

  assign w_alloc_oh = w_alloc                ? (ONE_HOT0 << w_free_id)                    : NONE;
  assign w_alu_oh   = clr_valid_ALU_Scb      ? (ONE_HOT0 << clr_ScbID_ALU_Scb)            : NONE;
  assign w_mem_oh   = clr_valid_MEM_Scb      ? (ONE_HOT0 << clr_ScbID_MEM_Scb)            : NONE;
  assign w_rc_oh    = replay_complete_IB_Scb ? (ONE_HOT0 << replay_complete_ScbID_IB_Scb) : NONE;

  // Both ports naming the same entry collapse into a single clear. A clear of
  // an invalid entry (including the one being allocated) is dropped and flagged.
  assign w_clr_oh  = (w_alu_oh | w_mem_oh) & r_valid;
  assign w_clr_bad = |((w_alu_oh | w_mem_oh) & ~r_valid);

  // Replay completion only counts for a valid, still-incomplete entry of the
  // matching LW/SW kind; anything else is a level-held request and is ignored.
  assign w_rc_ok = w_rc_oh & r_valid & r_incomplete &
                   (replay_SW_LWbar_IB_Scb ? r_is_sw : ~r_is_sw);

  assign w_pending_nx    = r_pending & ~w_clr_oh;
  assign w_incomplete_nx = r_incomplete & ~w_rc_ok;
  // Release looks at next-state flags so final clear + final replay in one
  // cycle frees the entry at that same edge.
  assign w_valid_nx      = r_valid & (w_pending_nx | w_incomplete_nx);

  assign w_err_nx = r_err | (RP_grt_IB_Scb & w_full) | w_clr_bad;

  // Hazard check against registered entries only (no same-cycle clear bypass).
  always_comb begin
    w_dep = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_dep = w_dep | (r_valid[i] & r_dst_valid[i] &
                       ((src1_valid_IB_Scb & (src1_IB_Scb == r_dst[i])) |
                        (src2_valid_IB_Scb & (src2_IB_Scb == r_dst[i])) |
                        (dst_valid_IB_Scb  & (dst_IB_Scb  == r_dst[i]))));
    end
  end

  // Entry state update: allocation writes a fresh entry, otherwise apply clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= NONE;
      r_dst_valid  <= NONE;
      r_pending    <= NONE;
      r_incomplete <= NONE;
      r_is_sw      <= NONE;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_dst[i] <= 5'd0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_alloc_oh[i]) begin
          r_valid[i]      <= 1'b1;
          r_pending[i]    <= 1'b1;
          r_incomplete[i] <= replayable_IB_Scb;
          r_is_sw[i]      <= replayable_IB_Scb & ~dst_valid_IB_Scb;
          r_dst_valid[i]  <= dst_valid_IB_Scb;
          r_dst[i]        <= dst_IB_Scb;
        end else begin
          r_valid[i]      <= w_valid_nx[i];
          r_pending[i]    <= w_pending_nx[i];
          r_incomplete[i] <= w_incomplete_nx[i];
          r_is_sw[i]      <= r_is_sw[i];
          r_dst_valid[i]  <= r_dst_valid[i];
          r_dst[i]        <= r_dst[i];
        end
      end
    end
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nx;
    end
  end

  assign full_Scb_IB      = w_full;
  assign empty_Scb_IB     = w_empty;
  assign dependent_Scb_IB = w_dep;
  assign ScbID_Scb_IB     = w_free_id;
  assign err_Scb          = r_err;

endmodule

// File: tb/tb_scoreboard_warp.sv
module tb_scoreboard_warp;

  logic       clk;
  logic       rst;
  logic [4:0] src1_IB_Scb, src2_IB_Scb, dst_IB_Scb;
  logic       src1_valid_IB_Scb, src2_valid_IB_Scb, dst_valid_IB_Scb;
  logic       RP_grt_IB_Scb, replayable_IB_Scb;
  logic       replay_complete_IB_Scb;
  logic [1:0] replay_complete_ScbID_IB_Scb;
  logic       replay_SW_LWbar_IB_Scb;
  logic       clr_valid_ALU_Scb;
  logic [1:0] clr_ScbID_ALU_Scb;
  logic       clr_valid_MEM_Scb;
  logic [1:0] clr_ScbID_MEM_Scb;
  logic       full_Scb_IB, empty_Scb_IB, dependent_Scb_IB, err_Scb;
  logic [1:0] ScbID_Scb_IB;

  int checks   = 0;
  int failures = 0;

  scoreboard_warp #(.NUM_ENTRIES(4)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .src1_IB_Scb                  (src1_IB_Scb),
    .src2_IB_Scb                  (src2_IB_Scb),
    .dst_IB_Scb                   (dst_IB_Scb),
    .src1_valid_IB_Scb            (src1_valid_IB_Scb),
    .src2_valid_IB_Scb            (src2_valid_IB_Scb),
    .dst_valid_IB_Scb             (dst_valid_IB_Scb),
    .RP_grt_IB_Scb                (RP_grt_IB_Scb),
    .replayable_IB_Scb            (replayable_IB_Scb),
    .replay_complete_IB_Scb       (replay_complete_IB_Scb),
    .replay_complete_ScbID_IB_Scb (replay_complete_ScbID_IB_Scb),
    .replay_SW_LWbar_IB_Scb       (replay_SW_LWbar_IB_Scb),
    .clr_valid_ALU_Scb            (clr_valid_ALU_Scb),
    .clr_ScbID_ALU_Scb            (clr_ScbID_ALU_Scb),
    .clr_valid_MEM_Scb            (clr_valid_MEM_Scb),
    .clr_ScbID_MEM_Scb            (clr_ScbID_MEM_Scb),
    .full_Scb_IB                  (full_Scb_IB),
    .empty_Scb_IB                 (empty_Scb_IB),
    .dependent_Scb_IB             (dependent_Scb_IB),
    .ScbID_Scb_IB                 (ScbID_Scb_IB),
    .err_Scb                      (err_Scb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = inputs held for one cycle, plus the outputs expected while
  // they are held (i.e. before the edge that consumes them). eid=-1: don't care.
  typedef struct {
    int grt, repl, dv, dst, s1v, s1, s2v, s2;
    int av, aid, mv, mid, rc, rcid, sw;
    int ef, ee, ed, eid, eerr;
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];

  function automatic vec_t V(
    input int grt, input int repl, input int dv, input int dst,
    input int s1v, input int s1, input int s2v, input int s2,
    input int av, input int aid, input int mv, input int mid,
    input int rc, input int rcid, input int sw,
    input int ef, input int ee, input int ed, input int eid, input int eerr);
    vec_t v;
    v.grt = grt; v.repl = repl; v.dv = dv; v.dst = dst;
    v.s1v = s1v; v.s1 = s1; v.s2v = s2v; v.s2 = s2;
    v.av = av; v.aid = aid; v.mv = mv; v.mid = mid;
    v.rc = rc; v.rcid = rcid; v.sw = sw;
    v.ef = ef; v.ee = ee; v.ed = ed; v.eid = eid; v.eerr = eerr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RP_grt_IB_Scb                = v.grt[0];
    replayable_IB_Scb            = v.repl[0];
    dst_valid_IB_Scb             = v.dv[0];
    dst_IB_Scb                   = v.dst[4:0];
    src1_valid_IB_Scb            = v.s1v[0];
    src1_IB_Scb                  = v.s1[4:0];
    src2_valid_IB_Scb            = v.s2v[0];
    src2_IB_Scb                  = v.s2[4:0];
    clr_valid_ALU_Scb            = v.av[0];
    clr_ScbID_ALU_Scb            = v.aid[1:0];
    clr_valid_MEM_Scb            = v.mv[0];
    clr_ScbID_MEM_Scb            = v.mid[1:0];
    replay_complete_IB_Scb       = v.rc[0];
    replay_complete_ScbID_IB_Scb = v.rcid[1:0];
    replay_SW_LWbar_IB_Scb       = v.sw[0];
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".full"},  idx, int'(full_Scb_IB),      v.ef);
    chk({tag, ".empty"}, idx, int'(empty_Scb_IB),     v.ee);
    chk({tag, ".dep"},   idx, int'(dependent_Scb_IB), v.ed);
    chk({tag, ".err"},   idx, int'(err_Scb),          v.eerr);
    if (v.eid >= 0) begin
      chk({tag, ".id"}, idx, int'(ScbID_Scb_IB), v.eid);
    end
  endtask

  initial begin
    vec_t idle;
    idle = V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0);

    //        grt rp dv dst s1v s1 s2v s2 av aid mv mid rc id sw   F E D id err
    // Table A: fill, overflow, simultaneous events
    ta.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // reset state
    ta.push_back(V(1,0,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // grant dst1 -> id0
    ta.push_back(V(1,0,1,2, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 1,0)); // grant dst2 -> id1
    ta.push_back(V(1,0,1,3, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 2,0)); // grant dst3 -> id2
    ta.push_back(V(1,0,1,4, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 3,0)); // grant dst4 -> id3
    ta.push_back(V(1,0,1,5, 0,0,0,0, 0,0,0,0, 0,0,0,  1,0,0,-1,0)); // 5th grant while full
    ta.push_back(V(0,0,1,5, 0,0,0,0, 0,0,0,0, 0,0,0,  1,0,0,-1,1)); // dst5 never written
    ta.push_back(V(0,0,0,0, 1,3,0,0, 0,0,0,0, 0,0,0,  1,0,1,-1,1)); // RAW on src1=3
    ta.push_back(V(0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0,0,  1,0,0,-1,1)); // ALU clear id0
    ta.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 0,1)); // id0 free again
    ta.push_back(V(1,0,1,6, 0,0,1,2, 1,1,1,2, 0,0,0,  0,0,1, 0,1)); // grant + ALU1 + MEM2
    ta.push_back(V(0,0,0,0, 1,2,1,3, 0,0,0,0, 0,0,0,  0,0,0, 1,1)); // 1,2 freed
    ta.push_back(V(0,0,0,0, 1,6,0,0, 0,0,0,0, 0,0,0,  0,0,1, 1,1)); // granted dst6 valid
    ta.push_back(V(1,0,1,7, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 1,1)); // grant dst7 -> id1
    ta.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,0, 2,1)); // entries 0,1,3 valid

    // Table B: dependencies, replay, error on invalid clear
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // after reset
    tb.push_back(V(1,0,1,5, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // grant dst5
    tb.push_back(V(0,0,0,0, 1,5,0,0, 1,0,0,0, 0,0,0,  0,0,1, 1,0)); // RAW, no clear bypass
    tb.push_back(V(0,0,0,0, 1,5,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // freed
    tb.push_back(V(1,0,1,7, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // grant dst7
    tb.push_back(V(0,0,1,7, 0,0,0,0, 0,0,0,0, 0,0,0,  0,0,1, 1,0)); // WAW
    tb.push_back(V(0,0,0,7, 0,7,0,7, 0,0,0,0, 0,0,0,  0,0,0, 1,0)); // flags off -> no hazard
    tb.push_back(V(0,0,0,0, 0,0,0,0, 1,0,1,0, 0,0,0,  0,0,0, 1,0)); // ALU+MEM same id
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // one clear, no err
    tb.push_back(V(1,1,1,9, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // LW dst9
    tb.push_back(V(0,0,0,0, 1,9,0,0, 0,0,1,0, 0,0,0,  0,0,1, 1,0)); // MEM pass clear
    tb.push_back(V(0,0,0,0, 0,0,1,9, 0,0,0,0, 1,0,1,  0,0,1, 1,0)); // still blocked; SW rc
    tb.push_back(V(0,0,0,0, 1,9,0,0, 0,0,0,0, 1,0,0,  0,0,1, 1,0)); // mismatch ignored; LW rc
    tb.push_back(V(0,0,0,0, 1,9,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // released
    tb.push_back(V(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // SW grant
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,  0,0,0, 1,0)); // LW rc on SW ignored
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0,1,  0,0,0, 1,0)); // SW rc, pending held
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,1,0, 0,0,0,  0,0,0, 1,0)); // MEM clear -> release
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // empty
    tb.push_back(V(1,1,1,9, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // LW dst9
    tb.push_back(V(0,0,0,0, 1,9,0,0, 0,0,1,0, 1,0,0,  0,0,1, 1,0)); // clear + rc same cycle
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,0)); // released at that edge
    tb.push_back(V(0,0,0,0, 0,0,0,0, 1,2,0,0, 0,0,0,  0,1,0, 0,0)); // clear invalid id2
    tb.push_back(V(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,  0,1,0, 0,1)); // err set

    drive(idle);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < ta.size(); i++) run_vec("A", i, ta[i]);

    // Asynchronous reset mid-cycle with 3 entries valid and err set.
    @(negedge clk);
    drive(idle);
    #2;
    rst = 1'b0;
    #1;
    chk("rst.empty", 0, int'(empty_Scb_IB), 1);
    chk("rst.full",  0, int'(full_Scb_IB),  0);
    chk("rst.err",   0, int'(err_Scb),      0);
    chk("rst.id",    0, int'(ScbID_Scb_IB), 0);
    // A grant held across an edge during reset must be ignored.
    RP_grt_IB_Scb    = 1'b1;
    dst_valid_IB_Scb = 1'b1;
    dst_IB_Scb       = 5'd3;
    @(posedge clk);
    #1;
    chk("rst.hold_empty", 0, int'(empty_Scb_IB), 1);
    chk("rst.hold_err",   0, int'(err_Scb),      0);
    @(negedge clk);
    drive(idle);
    rst = 1'b1;

    for (int i = 0; i < tb.size(); i++) run_vec("B", i, tb[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
